// File: rtl/fifo_sync_flex.sv
// fifo_sync_flex: single-clock parametrised FIFO with occupancy count,
// almost-full/almost-empty thresholds, synchronous flush, and sticky
// overflow/underflow flags. Standard (registered) or first-word-fall-through read.
//
// Ports:
//   i_clock        sole clock, all state updates on posedge
//   i_reset        synchronous active-high reset
//   i_flush        synchronous clear of contents (error flags untouched)
//   i_err_clear    clears o_overflow / o_underflow
//   i_data_in      write data
//   i_write_en     write request
//   o_fifo_full    no free entries
//   o_almost_full  fill level >= AF_THRESH
//   o_data_out     read data (registered, or live head when FWFT=1)
//   i_read_en      read request / pop
//   o_fifo_empty   no stored entries
//   o_almost_empty fill level <= AE_THRESH
//   o_fill_level   occupancy 0..DEPTH
//   o_overflow     sticky: write attempted while full
//   o_underflow    sticky: read attempted while empty
module fifo_sync_flex #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          FWFT       = 1'b0,
  parameter int unsigned AF_THRESH  = 2**ADDR_WIDTH - 2,
  parameter int unsigned AE_THRESH  = 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_flush,
  input  logic                  i_err_clear,
  input  logic [DATA_WIDTH-1:0] i_data_in,
  input  logic                  i_write_en,
  output logic                  o_fifo_full,
  output logic                  o_almost_full,
  output logic [DATA_WIDTH-1:0] o_data_out,
  input  logic                  i_read_en,
  output logic                  o_fifo_empty,
  output logic                  o_almost_empty,
  output logic [ADDR_WIDTH:0]   o_fill_level,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int unsigned       DEPTH  = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] AF_LVL = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_LVL = (ADDR_WIDTH+1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH:0]   r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic                  r_overflow;
  logic                  r_underflow;

  logic [ADDR_WIDTH-1:0] w_wr_idx;
  logic [ADDR_WIDTH-1:0] w_rd_idx;
  logic [ADDR_WIDTH:0]   w_fill;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_accept;
  logic                  w_rd_accept;
  logic                  w_ovf_set;
  logic                  w_udf_set;

  assign w_wr_idx = r_wr_ptr[ADDR_WIDTH-1:0];
  assign w_rd_idx = r_rd_ptr[ADDR_WIDTH-1:0];

  // Wrap bit distinguishes full (MSBs differ) from empty (pointers equal).
  assign w_full  = (w_wr_idx == w_rd_idx) && (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_fill  = r_wr_ptr - r_rd_ptr;

  // Flush and reset swallow any same-cycle request without raising errors.
  assign w_wr_accept = i_write_en & ~w_full  & ~i_flush & ~i_reset;
  assign w_rd_accept = i_read_en  & ~w_empty & ~i_flush & ~i_reset;
  assign w_ovf_set   = i_write_en & w_full   & ~i_flush;
  assign w_udf_set   = i_read_en  & w_empty  & ~i_flush;

  // Storage is never reset.
  always_ff @(posedge i_clock) begin
    if (w_wr_accept) begin
      r_mem[w_wr_idx] <= i_data_in;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_accept) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // A new error in the same cycle as err_clear keeps the flag set.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= w_ovf_set | (r_overflow  & ~i_err_clear);
      r_underflow <= w_udf_set | (r_underflow & ~i_err_clear);
    end
  end

  if (FWFT) begin : g_fwft
    assign o_data_out = r_mem[w_rd_idx];
  end else begin : g_std
    logic [DATA_WIDTH-1:0] r_data_out;

    // Holds through flush and rejected reads; only an accepted read updates it.
    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        r_data_out <= '0;
      end else if (w_rd_accept) begin
        r_data_out <= r_mem[w_rd_idx];
      end
    end

    assign o_data_out = r_data_out;
  end

  assign o_fifo_full    = w_full;
  assign o_fifo_empty   = w_empty;
  assign o_almost_full  = (w_fill >= AF_LVL);
  assign o_almost_empty = (w_fill <= AE_LVL);
  assign o_fill_level   = w_fill;
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_sync_flex.sv
// Bench for fifo_sync_flex: a standard-read and an FWFT instance share one
// stimulus stream and are compared against a queue-based reference model.
module tb_fifo_sync_flex;

  localparam int DEPTH = 32;
  localparam int AF    = 30;
  localparam int AE    = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fl  = 1'b0;
  logic       ec  = 1'b0;
  logic       we  = 1'b0;
  logic       re  = 1'b0;
  logic [7:0] din = 8'h00;

  logic       s_full, s_af, s_empty, s_ae, s_ovf, s_udf;
  logic [7:0] s_dout;
  logic [5:0] s_fill;
  logic       f_full, f_af, f_empty, f_ae, f_ovf, f_udf;
  logic [7:0] f_dout;
  logic [5:0] f_fill;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] q[$];
  logic       m_ovf  = 1'b0;
  logic       m_udf  = 1'b0;
  logic [7:0] m_dout = 8'h00;

  always #5 clk = ~clk;

  fifo_sync_flex #(.FWFT(1'b0)) u_std (
    .i_clock(clk), .i_reset(rst), .i_flush(fl), .i_err_clear(ec),
    .i_data_in(din), .i_write_en(we), .o_fifo_full(s_full), .o_almost_full(s_af),
    .o_data_out(s_dout), .i_read_en(re), .o_fifo_empty(s_empty), .o_almost_empty(s_ae),
    .o_fill_level(s_fill), .o_overflow(s_ovf), .o_underflow(s_udf)
  );

  fifo_sync_flex #(.FWFT(1'b1)) u_fwft (
    .i_clock(clk), .i_reset(rst), .i_flush(fl), .i_err_clear(ec),
    .i_data_in(din), .i_write_en(we), .o_fifo_full(f_full), .o_almost_full(f_af),
    .o_data_out(f_dout), .i_read_en(re), .o_fifo_empty(f_empty), .o_almost_empty(f_ae),
    .o_fill_level(f_fill), .o_overflow(f_ovf), .o_underflow(f_udf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model of one clock edge, from the pre-edge state and inputs.
  task automatic model_edge();
    bit wacc, racc, oset, uset;
    if (rst) begin
      q.delete();
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_dout = 8'h00;
    end else begin
      oset = 1'b0;
      uset = 1'b0;
      if (fl) begin
        q.delete();
      end else begin
        wacc = we && (q.size() < DEPTH);
        racc = re && (q.size() > 0);
        oset = we && !wacc;
        uset = re && !racc;
        if (racc) m_dout = q.pop_front();
        if (wacc) q.push_back(din);
      end
      m_ovf = oset | (m_ovf & ~ec);
      m_udf = uset | (m_udf & ~ec);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("fill_std",  32'(s_fill),  32'(n));
    chk("fill_fwft", 32'(f_fill),  32'(n));
    chk("empty",     32'(s_empty), 32'(n == 0));
    chk("full",      32'(s_full),  32'(n == DEPTH));
    chk("afull",     32'(s_af),    32'(n >= AF));
    chk("aempty",    32'(s_ae),    32'(n <= AE));
    chk("ovf",       32'(s_ovf),   32'(m_ovf));
    chk("udf",       32'(s_udf),   32'(m_udf));
    chk("flags_fwft", {26'd0, f_empty, f_full, f_af, f_ae, f_ovf, f_udf},
        {26'd0, 1'(n == 0), 1'(n == DEPTH), 1'(n >= AF), 1'(n <= AE), m_ovf, m_udf});
    chk("dout_std",  32'(s_dout),  32'(m_dout));
    if (n > 0) chk("dout_fwft", 32'(f_dout), 32'(q[0]));
  endtask

  task automatic step(input bit w, input bit r, input logic [7:0] d,
                      input bit f, input bit e, input bit rs);
    we  = w;
    re  = r;
    din = d;
    fl  = f;
    ec  = e;
    rst = rs;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    // Reset then idle
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("rst_dout", 32'(s_dout), 32'h0);
    chk("rst_empty", 32'(s_empty), 32'h1);

    // Fill with 0x00..0x1F, then write while full
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(i), 1'b0, 1'b0, 1'b0);
    chk("full_after_32", 32'(s_full), 32'h1);
    step(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", 32'(s_ovf), 32'h1);

    // Drain, checking the registered read data order, then read while empty
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("drain_order", 32'(s_dout), 32'(i));
    end
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("udf_set", 32'(s_udf), 32'h1);
    chk("dout_hold_udf", 32'(s_dout), 32'h1F);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("err_cleared", {30'd0, s_ovf, s_udf}, 32'h0);

    // Fill to 16 then stream write+read across the pointer wrap
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    chk("stream_fill16", 32'(s_fill), 32'd16);

    // Randomised traffic with alternating fill/drain bias
    for (int i = 0; i < 600; i++) begin
      int pw;
      pw = ((i / 100) % 2 == 0) ? 75 : 25;
      step(1'($urandom_range(0, 99) < pw), 1'($urandom_range(0, 99) < 100 - pw),
           8'($urandom), 1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 199) == 0));
    end

    // FWFT head visibility
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
    chk("fwft_a5", 32'(f_dout), 32'hA5);
    chk("fwft_nonempty", 32'(f_empty), 32'h0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("fwft_popped", 32'(f_empty), 32'h1);

    // Fill to 10, flush with a concurrent write
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h77, 1'b1, 1'b0, 1'b0);
    chk("flush_fill", 32'(s_fill), 32'h0);
    chk("flush_no_ovf", 32'(s_ovf), 32'h0);

    // Reset mid-stream
    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 1'b0,
                                     1'b0);
    step(1'b1, 1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
    chk("midrst_fill", 32'(s_fill), 32'h0);
    chk("midrst_dout", 32'(s_dout), 32'h0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
